// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with byte-lane writes plus an MMIO window
// holding a console TX FIFO, a 64-bit cycle counter and a halt/exit-code register.
module dmem_responder #(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_we_i,
  output logic [31:0] data_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        halt_o,
  output logic [31:0] exit_code_o,
  output logic        bus_err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [FW:0] FIFO_FULL = (FW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [7:0]    r_buf [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr, r_wr_ptr;
  logic [FW:0]   r_count;
  logic [15:0]   r_drop;
  logic [63:0]   r_cycle;
  logic          r_halt;
  logic [31:0]   r_exit;
  logic          r_err;

  logic          w_wr, w_is_ram, w_is_mmio, w_known_off;
  logic [5:0]    w_off;
  logic          w_full, w_empty, w_push, w_pop, w_accept, w_drop;
  logic [AW-1:0] w_widx;

  assign w_wr        = |data_we_i;
  assign w_widx      = data_addr_i[AW+1:2];
  assign w_is_ram    = data_addr_i < RAM_BYTES;
  // MMIO_BASE is assumed 256-byte aligned.
  assign w_is_mmio   = data_addr_i[31:8] == MMIO_BASE[31:8];
  assign w_off       = data_addr_i[7:2];
  assign w_known_off = w_off <= 6'd4;

  assign w_full   = r_count == FIFO_FULL;
  assign w_empty  = r_count == '0;
  assign w_push   = w_is_mmio && (w_off == 6'd0) && data_we_i[0];
  assign w_pop    = !w_empty && tx_ready_i;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_we_i[i]) r_mem[w_widx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
    if (w_accept) r_buf[r_wr_ptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_cycle  <= '0;
      r_halt   <= 1'b0;
      r_exit   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_accept) r_count <= r_count - 1'b1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (!r_halt) r_cycle <= r_cycle + 64'd1;
      if (w_wr && w_is_mmio && (w_off == 6'd4) && !r_halt) begin
        r_halt <= 1'b1;
        r_exit <= data_wdata_i;
      end
      if (w_wr && !w_is_ram && !(w_is_mmio && w_known_off)) r_err <= 1'b1;
    end
  end

  always_comb begin
    data_rdata_o = '0;
    if (w_is_ram) begin
      data_rdata_o = r_mem[w_widx];
    end else if (w_is_mmio) begin
      unique case (w_off)
        6'd1:    data_rdata_o = {r_drop, 8'(r_count), 6'b0, w_empty, w_full};
        6'd2:    data_rdata_o = r_cycle[31:0];
        6'd3:    data_rdata_o = r_cycle[63:32];
        6'd4:    data_rdata_o = {31'b0, r_halt};
        default: data_rdata_o = '0;
      endcase
    end
  end

  assign tx_valid_o  = !w_empty;
  assign tx_data_o   = w_empty ? 8'h00 : r_buf[r_rd_ptr];
  assign halt_o      = r_halt;
  assign exit_code_o = r_exit;
  assign bus_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o, exit_code_o;
  logic [3:0]  data_we_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i, halt_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .MEM_WORDS (4096),
    .MMIO_BASE (MB),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_addr_i (data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_we_i   (data_we_i),
    .data_rdata_o(data_rdata_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .halt_o      (halt_o),
    .exit_code_o (exit_code_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    data_addr_i  = a;
    data_wdata_i = d;
    data_we_i    = we;
    @(posedge clk);
    #1 data_we_i = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    data_addr_i = a;
    #1 chk(tag, data_rdata_o, exp);
  endtask

  initial begin
    rst = 1'b1; data_addr_i = '0; data_wdata_i = '0; data_we_i = '0; tx_ready_i = 1'b0;
    #12;
    chk("rst_valid", {31'b0, tx_valid_o}, 0);
    chk("rst_halt", {31'b0, halt_o}, 0);
    chk("rst_exit", exit_code_o, 0);
    chk("rst_err", {31'b0, bus_err_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 100 posedges after release -> counter = 100
    repeat (100) @(posedge clk);
    @(negedge clk);
    rd("cycle_lo_100", MB + 32'h08, 32'd100);
    rd("cycle_hi_0", MB + 32'h0C, 32'd0);
    // counter reaches 101 at next edge, then 102 on the halt-write edge and freezes
    wr(MB + 32'h10, 32'h2A, 4'h1);
    chk("halt_set", {31'b0, halt_o}, 1);
    chk("exit_2a", exit_code_o, 32'h2A);
    repeat (5) @(posedge clk);
    rd("cycle_frozen", MB + 32'h08, 32'd102);
    wr(MB + 32'h10, 32'h7, 4'hF);
    chk("exit_kept", exit_code_o, 32'h2A);
    rd("halt_read", MB + 32'h10, 32'd1);

    // RAM byte lanes
    wr(32'h0, 32'h1234_5678, 4'hF);
    wr(32'h100, 32'hAABB_CCDD, 4'hF);
    @(negedge clk);
    data_addr_i = 32'h100; data_wdata_i = 32'h0000_1100; data_we_i = 4'b0010;
    #1 chk("ram_same_cycle", data_rdata_o, 32'hAABB_CCDD);
    @(posedge clk);
    #1 data_we_i = 4'h0;
    rd("ram_lane1", 32'h100, 32'hAABB_11DD);
    rd("ram_word0", 32'h0, 32'h1234_5678);

    // FIFO fill and overflow
    for (int i = 0; i < 10; i++) wr(MB, 32'h41 + i, 4'h1);
    rd("status_full", MB + 32'h04, 32'h0002_0801);
    rd("tx_reads0", MB, 32'h0);
    chk("head_41", {24'b0, tx_data_o}, 32'h41);
    // full push with simultaneous pop
    @(negedge clk);
    data_addr_i = MB; data_wdata_i = 32'h5A; data_we_i = 4'h1; tx_ready_i = 1'b1;
    @(posedge clk);
    #1 data_we_i = 4'h0; tx_ready_i = 1'b0;
    rd("status_pushpop", MB + 32'h04, 32'h0002_0801);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'b0, tx_valid_o}, 1);
      chk("drain_data", {24'b0, tx_data_o}, (i == 7) ? 32'h5A : 32'h42 + i);
      @(posedge clk);
      #1;
    end
    tx_ready_i = 1'b0;
    chk("drained_valid", {31'b0, tx_valid_o}, 0);
    chk("drained_data", {24'b0, tx_data_o}, 0);
    rd("status_empty", MB + 32'h04, 32'h0002_0002);

    // unmapped and error
    chk("err_before", {31'b0, bus_err_o}, 0);
    wr(32'h0000_4000, 32'hDEAD_BEEF, 4'hF);
    chk("err_ram_end", {31'b0, bus_err_o}, 1);
    rd("ram_no_alias", 32'h0, 32'h1234_5678);
    rd("unmapped_read", 32'h2000_0000, 32'h0);

    // mid-operation reset with occupancy 5 and halt set
    for (int i = 0; i < 5; i++) wr(MB, 32'h61 + i, 4'h1);
    rd("status_occ5", MB + 32'h04, 32'h0002_0500);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, tx_valid_o}, 0);
    chk("mrst_data", {24'b0, tx_data_o}, 0);
    chk("mrst_halt", {31'b0, halt_o}, 0);
    chk("mrst_exit", exit_code_o, 0);
    chk("mrst_err", {31'b0, bus_err_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    rd("mrst_ram", 32'h100, 32'hAABB_11DD);
    rd("mrst_status", MB + 32'h04, 32'h0000_0002);
    wr(MB + 32'h04, 32'h1, 4'hF);
    chk("ro_write_noerr", {31'b0, bus_err_o}, 0);
    wr(MB + 32'h14, 32'h1, 4'hF);
    chk("err_mmio_14", {31'b0, bus_err_o}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
